// File: rtl/useq_pkg.sv
// Shared definitions for the microprogram sequencer: test-field encodings and default sizing.
// The microcode assembler tables use the same encodings.
package useq_pkg;

  typedef enum logic [3:0] {
    T_SEQ   = 4'd0,
    T_JMP   = 4'd1,
    T_DISP  = 4'd2,
    T_BR_S  = 4'd3,
    T_BR_NZ = 4'd4,
    T_BR_Z  = 4'd5,
    T_BR_C  = 4'd6,
    T_BR_O  = 4'd7,
    T_CALL  = 4'd8,
    T_RET   = 4'd9,
    T_HALT  = 4'd10
  } test_e;

  localparam int UADDR_W_DEF     = 6;
  localparam int OPC_W_DEF       = 4;
  localparam int STACK_DEPTH_DEF = 4;
  localparam int RESET_ADDR_DEF  = 1;

endpackage

// File: rtl/useq_stack.sv
// Micro-subroutine return stack: small LIFO with occupancy count.
// Push on full and pop on empty are ignored here; the caller flags them as errors.
module useq_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 6,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     top,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem [DEPTH];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign wr_idx = IDX_W'(count);
  assign rd_idx = IDX_W'(count - CNT_W'(1));
  assign top    = mem[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      count <= count - CNT_W'(1);
    end
  end

  // Contents need no reset: only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_idx] <= din;
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: registered uPC, next-address selection from the microword test field,
// programmable opcode dispatch map, return stack, stall/halt and sticky error flags.
module micro_sequencer
  import useq_pkg::*;
#(
  parameter int UADDR_W     = UADDR_W_DEF,
  parameter int OPC_W       = OPC_W_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF,
  parameter int RESET_ADDR  = RESET_ADDR_DEF,
  localparam int SP_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic [3:0]         test,
  input  logic [UADDR_W-1:0] uaddr,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               cf,
  input  logic               zf,
  input  logic               sf,
  input  logic               of,
  input  logic               map_we,
  input  logic [OPC_W-1:0]   map_opc,
  input  logic [UADDR_W-1:0] map_addr,
  input  logic               err_clr,
  output logic [UADDR_W-1:0] upc,
  output logic               halted,
  output logic [SP_W-1:0]    sp,
  output logic               err_ovf,
  output logic               err_unf,
  output logic               err_map
);

  localparam int MAP_N = 2 ** OPC_W;
  localparam logic [UADDR_W-1:0] RST_UPC = UADDR_W'(RESET_ADDR);

  logic [MAP_N-1:0]   map_vld;
  logic [UADDR_W-1:0] map_tgt [MAP_N];

  logic [UADDR_W-1:0] upc_inc;
  logic [UADDR_W-1:0] upc_nxt;
  logic [UADDR_W-1:0] stk_top;
  logic               stk_full;
  logic               stk_empty;
  logic               push_req;
  logic               pop_req;
  logic               take;
  logic               set_ovf;
  logic               set_unf;
  logic               set_map;

  always_comb begin
    upc_inc  = upc + UADDR_W'(1);
    upc_nxt  = upc_inc;
    push_req = 1'b0;
    pop_req  = 1'b0;
    take     = 1'b0;
    set_ovf  = 1'b0;
    set_unf  = 1'b0;
    set_map  = 1'b0;
    case (test)
      T_JMP:   upc_nxt = uaddr;
      T_DISP: begin
        // Combinational read of the map: a same-cycle write lands after this lookup.
        if (map_vld[opcode]) begin
          upc_nxt = map_tgt[opcode];
        end else begin
          upc_nxt = uaddr;
          set_map = 1'b1;
        end
      end
      T_BR_S:  take = sf;
      T_BR_NZ: take = !zf;
      T_BR_Z:  take = zf;
      T_BR_C:  take = cf;
      T_BR_O:  take = of;
      T_CALL: begin
        upc_nxt  = uaddr;
        push_req = !stk_full;
        set_ovf  = stk_full;
      end
      T_RET: begin
        if (stk_empty) begin
          upc_nxt = RST_UPC;
          set_unf = 1'b1;
        end else begin
          upc_nxt = stk_top;
          pop_req = 1'b1;
        end
      end
      T_HALT:  upc_nxt = upc;
      default: ;
    endcase
    if (take) upc_nxt = uaddr;
  end

  useq_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (UADDR_W)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req && !stall),
    .pop   (pop_req && !stall),
    .din   (upc_inc),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty),
    .count (sp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upc     <= RST_UPC;
      halted  <= 1'b0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
      err_map <= 1'b0;
      map_vld <= '0;
    end else begin
      if (!stall) begin
        upc    <= upc_nxt;
        halted <= (test == T_HALT);
      end
      // A new error in the same cycle as err_clr stays set.
      err_ovf <= (set_ovf && !stall) || (err_ovf && !err_clr);
      err_unf <= (set_unf && !stall) || (err_unf && !err_clr);
      err_map <= (set_map && !stall) || (err_map && !err_clr);
      if (map_we) map_vld[map_opc] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (map_we) map_tgt[map_opc] <= map_addr;
  end

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Parametrised microprogram sequencer for the CPU control unit: holds the micro-program counter (uPC), computes the next control-store address from the test field of the current microword, the opcode, and the ALU flags, and supports opcode dispatch through a run-time programmable map, conditional branches, micro-subroutine call/return on a LIFO stack, stall, and halt. It sits between the control store (which returns the microword at `upc`) and the datapath flag register.

## Interface
- `UADDR_W`, 6: micro-address width; uPC and all address fields.
- `OPC_W`, 4: opcode width; the dispatch map has 2^OPC_W entries.
- `STACK_DEPTH`, 4: return-stack entries (≥1).
- `RESET_ADDR`, 1: uPC value after reset and after stack underflow.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  freeze: uPC, stack and error flags hold.
- `test`  in  4  test field of the current microword.
- `uaddr`  in  UADDR_W  address field of the current microword.
- `opcode`  in  OPC_W  instruction opcode from the IR.
- `cf`, `zf`, `sf`, `of`  in  1 each  ALU flags, sampled the same cycle.
- `map_we`  in  1  write one dispatch-map entry.
- `map_opc`  in  OPC_W  entry index.
- `map_addr`  in  UADDR_W  target micro-address written.
- `err_clr`  in  1  clears all sticky error flags.
- `upc`  out  UADDR_W  registered address to the control store.
- `halted`  out  1  high while the uPC is held by HALT.
- `sp`  out  $clog2(STACK_DEPTH+1)  stack occupancy.
- `err_ovf`, `err_unf`, `err_map`  out  1 each  sticky: push on full, pop on empty, dispatch to an unmapped opcode.

## Operation
- Test encodings: 0 SEQ (upc+1); 1 JMP (uaddr); 2 DISP (map[opcode] if valid, else uaddr and set err_map); 3 BR_S (sf=1); 4 BR_NZ (zf=0); 5 BR_Z (zf=1); 6 BR_C (cf=1); 7 BR_O (of=1); 8 CALL (push upc+1, go uaddr); 9 RET (pop, go top); 10 HALT (hold upc, halted=1). Branches go to uaddr if the condition is true, else to upc+1. Encodings 11–15 behave as SEQ.
- upc+1 wraps modulo 2^UADDR_W. A pushed return address wraps the same way.
- CALL with the stack full: no push, jump still taken, err_ovf set.
- RET with the stack empty: upc ← RESET_ADDR, err_unf set.
- HALT: only reset or a different test value leaves HALT. Because `test` follows `upc`, HALT normally holds until reset.
- Dispatch map: 2^OPC_W entries, each a valid bit plus an address. `map_we` writes the entry and sets its valid bit. Writes proceed even while `stall` is high.
- Map write and DISP to the same index in the same cycle: DISP uses the old entry.
- `stall`=1: no state change except map writes and `err_clr`.
- `err_clr` is applied in the same cycle as a new error event: the set wins.

## Timing
- Reset (asynchronous):
  - upc=RESET_ADDR, sp=0, halted=0, all error flags 0.
  - All map valid bits cleared; stack contents don't-care.
- All outputs are registered. The next uPC appears one clock after the edge that sees the microword, i.e. one microinstruction per cycle with zero-bubble branches.
- Flags and opcode are used combinationally in the cycle they are presented. There is no internal flag register.
- CALL, then RET on the next cycle: RET returns the address pushed by that CALL.
- Reset deasserted mid-program: the sequencer restarts at RESET_ADDR with an empty stack and an empty map.

## Structure
- Package `useq_pkg`: the 4-bit test encoding enum (SEQ…HALT) and the default parameter constants. Shared with the microcode assembler tables.
- Sub-module `useq_stack`: a parametrised LIFO with push/pop/full/empty/count.
  - Same-cycle push and pop never occur, since CALL and RET are exclusive.
- Dispatch map: a flop array inside `micro_sequencer`, not RAM, so it gets a reset of its valid bits.

## Test plan
- Reset, then SEQ from upc=1 through 63 → upc reaches 63, then wraps to 0 (UADDR_W=6).
- Map opcode 4'b0010→3 and 4'b1011→4, then DISP with opcode=4'b0010 → upc=3; DISP with opcode 4'b0101 (unmapped, uaddr=20) → upc=20, err_map=1.
- BR_S uaddr=11: sf=1 → upc=11; sf=0 at upc=7 → upc=8. BR_NZ uaddr=13: zf=0 → 13; zf=1 → upc+1.
- Nested CALLs to depth 4 from upc 5,10,15,20, then 4 RETs → return to 21,16,11,6. A fifth CALL sets err_ovf and does not push. A RET on empty → upc=1, err_unf=1.
- stall held 3 cycles during a CALL microword → upc and sp unchanged. After release, one push occurs.
- map_we to index 2 with addr 9 in the same cycle as DISP opcode 2 (old entry 3) → upc=3. The next DISP → upc=9.
